// File: rtl/axis_adapter_pkg.sv
// axis_adapter_pkg: shared types and helpers for the AXI4-Stream width adapter.
//   state_e           downsize sequencer states
//   calc_seg_count    ratio between the wider and narrower keep widths
//   calc_lane_width   bits per keep lane
//   last_nonzero_seg  highest segment of a keep vector with any lane set
package axis_adapter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  // Widest keep vector the segment search supports.
  localparam int unsigned MaxKeepWidth = 64;

  function automatic int unsigned calc_seg_count(int unsigned in_keep, int unsigned out_keep);
    return (in_keep > out_keep) ? (in_keep / out_keep) : (out_keep / in_keep);
  endfunction

  function automatic int unsigned calc_lane_width(int unsigned data_w, int unsigned keep_w);
    return data_w / keep_w;
  endfunction

  // Returns 0 for an all-zero keep so an empty final beat still emits segment 0.
  function automatic int unsigned last_nonzero_seg(logic [MaxKeepWidth-1:0] keep,
                                                   int unsigned seg_keep,
                                                   int unsigned seg_count);
    logic [MaxKeepWidth-1:0] mask;
    int unsigned idx;
    idx  = 0;
    mask = (MaxKeepWidth'(1) << seg_keep) - MaxKeepWidth'(1);
    for (int unsigned s = 0; s < seg_count; s++) begin
      if (|((keep >> (s * seg_keep)) & mask)) idx = s;
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_adapter_if.sv
// axis_adapter_if: one AXI4-Stream link.
//   tdata/tkeep/tvalid/tlast/tuser  driven by the master
//   tready                          driven by the slave
interface axis_adapter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_adapter.sv
// axis_adapter: AXI4-Stream width adapter (downsize, upsize or pass-through).
// Byte order is lowest lane first; tlast/tuser frame boundaries are preserved and
// empty trailing segments of a final downsize beat are dropped.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   input_axis   slave stream, INPUT_DATA_WIDTH / INPUT_KEEP_WIDTH
//   output_axis  master stream, OUTPUT_DATA_WIDTH / OUTPUT_KEEP_WIDTH
module axis_adapter
  import axis_adapter_pkg::*;
#(
  parameter int unsigned INPUT_DATA_WIDTH  = 8,
  parameter int unsigned INPUT_KEEP_WIDTH  = INPUT_DATA_WIDTH / 8,
  parameter int unsigned OUTPUT_DATA_WIDTH = 8,
  parameter int unsigned OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH / 8
) (
  input logic             clk,
  input logic             rst,
  axis_adapter_if.slave   input_axis,
  axis_adapter_if.master  output_axis
);

  localparam int unsigned LANE_WIDTH = calc_lane_width(INPUT_DATA_WIDTH, INPUT_KEEP_WIDTH);

  // Holds input_axis.tready low until the first edge after reset release.
  logic ready_en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en_q <= 1'b0;
    else      ready_en_q <= 1'b1;
  end

  if (INPUT_KEEP_WIDTH > OUTPUT_KEEP_WIDTH) begin : g_down
    localparam int unsigned SEG_COUNT = calc_seg_count(INPUT_KEEP_WIDTH, OUTPUT_KEEP_WIDTH);
    localparam int unsigned SegW      = $clog2(SEG_COUNT);
    localparam int unsigned SegBits   = OUTPUT_KEEP_WIDTH * LANE_WIDTH;

    state_e                      state_q, state_d;
    logic [SegW-1:0]             seg_q, seg_d;
    logic [SegW-1:0]             final_q, final_d;
    logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
    logic [INPUT_KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                        last_q, last_d;
    logic                        user_q, user_d;
    logic                        final_seg, out_hs, accept;

    always_comb begin
      state_d = state_q;
      seg_d   = seg_q;
      final_d = final_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      user_d  = user_q;

      final_seg = (seg_q == final_q);
      out_hs    = (state_q == StSend) && output_axis.tready;
      // Ready again on the final segment's handshake so the next beat has no bubble.
      input_axis.tready = ready_en_q && ((state_q == StIdle) || (out_hs && final_seg));
      accept            = input_axis.tvalid && input_axis.tready;

      output_axis.tvalid = (state_q == StSend);
      output_axis.tdata  = OUTPUT_DATA_WIDTH'(data_q >> (seg_q * SegBits));
      output_axis.tkeep  = OUTPUT_KEEP_WIDTH'(keep_q >> (seg_q * OUTPUT_KEEP_WIDTH));
      output_axis.tlast  = (state_q == StSend) && final_seg && last_q;
      output_axis.tuser  = (state_q == StSend) && final_seg && last_q && user_q;

      if (out_hs) begin
        if (final_seg) state_d = StIdle;
        else           seg_d   = seg_q + SegW'(1);
      end

      if (accept) begin
        state_d = StSend;
        seg_d   = '0;
        data_d  = input_axis.tdata;
        keep_d  = input_axis.tkeep;
        last_d  = input_axis.tlast;
        user_d  = input_axis.tuser;
        final_d = input_axis.tlast
                ? SegW'(last_nonzero_seg(MaxKeepWidth'(input_axis.tkeep), OUTPUT_KEEP_WIDTH,
                                         SEG_COUNT))
                : SegW'(SEG_COUNT - 1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= StIdle;
        seg_q   <= '0;
        final_q <= '0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        user_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        seg_q   <= seg_d;
        final_q <= final_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
        user_q  <= user_d;
      end
    end

  end else if (OUTPUT_KEEP_WIDTH > INPUT_KEEP_WIDTH) begin : g_up
    localparam int unsigned SEG_COUNT = calc_seg_count(INPUT_KEEP_WIDTH, OUTPUT_KEEP_WIDTH);
    localparam int unsigned SegW      = $clog2(SEG_COUNT);
    localparam int unsigned SegBits   = INPUT_KEEP_WIDTH * LANE_WIDTH;

    logic [SegW-1:0]              seg_q, seg_d;
    logic [OUTPUT_DATA_WIDTH-1:0] acc_data_q, acc_data_d, out_data_q, out_data_d, word_data;
    logic [OUTPUT_KEEP_WIDTH-1:0] acc_keep_q, acc_keep_d, out_keep_q, out_keep_d, word_keep;
    logic                         acc_user_q, acc_user_d, word_user;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic                         out_user_q, out_user_d;
    logic                         accept, complete;

    always_comb begin
      seg_d       = seg_q;
      acc_data_d  = acc_data_q;
      acc_keep_d  = acc_keep_q;
      acc_user_d  = acc_user_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_user_d  = out_user_q;

      input_axis.tready = ready_en_q && !(out_valid_q && !output_axis.tready);
      accept            = input_axis.tvalid && input_axis.tready;

      // Unfilled segments of the accumulator are always zero, so OR packs the beat in place.
      word_data = acc_data_q | (OUTPUT_DATA_WIDTH'(input_axis.tdata) << (seg_q * SegBits));
      word_keep = acc_keep_q | (OUTPUT_KEEP_WIDTH'(input_axis.tkeep) << (seg_q * INPUT_KEEP_WIDTH));
      word_user = acc_user_q | input_axis.tuser;
      complete  = input_axis.tlast || (seg_q == SegW'(SEG_COUNT - 1));

      if (out_valid_q && output_axis.tready) out_valid_d = 1'b0;

      if (accept) begin
        if (complete) begin
          out_data_d  = word_data;
          out_keep_d  = word_keep;
          out_last_d  = input_axis.tlast;
          out_user_d  = word_user;
          out_valid_d = 1'b1;
          acc_data_d  = '0;
          acc_keep_d  = '0;
          acc_user_d  = 1'b0;
          seg_d       = '0;
        end else begin
          acc_data_d = word_data;
          acc_keep_d = word_keep;
          acc_user_d = word_user;
          seg_d      = seg_q + SegW'(1);
        end
      end

      output_axis.tvalid = out_valid_q;
      output_axis.tdata  = out_data_q;
      output_axis.tkeep  = out_keep_q;
      output_axis.tlast  = out_last_q;
      output_axis.tuser  = out_user_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        seg_q       <= '0;
        acc_data_q  <= '0;
        acc_keep_q  <= '0;
        acc_user_q  <= 1'b0;
        out_data_q  <= '0;
        out_keep_q  <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        out_user_q  <= 1'b0;
      end else begin
        seg_q       <= seg_d;
        acc_data_q  <= acc_data_d;
        acc_keep_q  <= acc_keep_d;
        acc_user_q  <= acc_user_d;
        out_data_q  <= out_data_d;
        out_keep_q  <= out_keep_d;
        out_valid_q <= out_valid_d;
        out_last_q  <= out_last_d;
        out_user_q  <= out_user_d;
      end
    end

  end else begin : g_pass
    logic [INPUT_KEEP_WIDTH*LANE_WIDTH-1:0] data_q, data_d;
    logic [INPUT_KEEP_WIDTH-1:0]            keep_q, keep_d;
    logic                                   valid_q, valid_d;
    logic                                   last_q, last_d;
    logic                                   user_q, user_d;

    always_comb begin
      data_d  = data_q;
      keep_d  = keep_q;
      valid_d = valid_q;
      last_d  = last_q;
      user_d  = user_q;

      input_axis.tready = ready_en_q && (!valid_q || output_axis.tready);
      if (input_axis.tready) begin
        valid_d = input_axis.tvalid;
        if (input_axis.tvalid) begin
          data_d = input_axis.tdata;
          keep_d = input_axis.tkeep;
          last_d = input_axis.tlast;
          user_d = input_axis.tuser;
        end
      end

      output_axis.tvalid = valid_q;
      output_axis.tdata  = data_q;
      output_axis.tkeep  = keep_q;
      output_axis.tlast  = last_q;
      output_axis.tuser  = user_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        keep_q  <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        user_q  <= 1'b0;
      end else begin
        data_q  <= data_d;
        keep_q  <= keep_d;
        valid_q <= valid_d;
        last_q  <= last_d;
        user_q  <= user_d;
      end
    end
  end

endmodule

// File: tb/tb_axis_adapter.sv
// tb_axis_adapter: directed bench for 64->8 downsize, 8->64 upsize and 32->32 pass-through.
module tb_axis_adapter;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  logic d_toggle;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int          cyc;
  } beat_t;

  beat_t d_q[$];
  beat_t u_q[$];
  beat_t p_q[$];

  axis_adapter_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) d_in ();
  axis_adapter_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1)) d_out ();
  axis_adapter_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1)) u_in ();
  axis_adapter_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) u_out ();
  axis_adapter_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) p_in ();
  axis_adapter_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) p_out ();

  axis_adapter #(
    .INPUT_DATA_WIDTH (64),
    .INPUT_KEEP_WIDTH (8),
    .OUTPUT_DATA_WIDTH(8),
    .OUTPUT_KEEP_WIDTH(1)
  ) u_down (
    .clk        (clk),
    .rst        (rst),
    .input_axis (d_in),
    .output_axis(d_out)
  );

  axis_adapter #(
    .INPUT_DATA_WIDTH (8),
    .INPUT_KEEP_WIDTH (1),
    .OUTPUT_DATA_WIDTH(64),
    .OUTPUT_KEEP_WIDTH(8)
  ) u_up (
    .clk        (clk),
    .rst        (rst),
    .input_axis (u_in),
    .output_axis(u_out)
  );

  axis_adapter #(
    .INPUT_DATA_WIDTH (32),
    .INPUT_KEEP_WIDTH (4),
    .OUTPUT_DATA_WIDTH(32),
    .OUTPUT_KEEP_WIDTH(4)
  ) u_pass (
    .clk        (clk),
    .rst        (rst),
    .input_axis (p_in),
    .output_axis(p_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors sample mid-cycle; a recorded beat handshakes on the next rising edge.
  always @(negedge clk) begin
    if (rst && d_out.tvalid && d_out.tready)
      d_q.push_back('{64'(d_out.tdata), 8'(d_out.tkeep), d_out.tlast, d_out.tuser, cyc});
    if (rst && u_out.tvalid && u_out.tready)
      u_q.push_back('{u_out.tdata, u_out.tkeep, u_out.tlast, u_out.tuser, cyc});
    if (rst && p_out.tvalid && p_out.tready)
      p_q.push_back('{64'(p_out.tdata), 8'(p_out.tkeep), p_out.tlast, p_out.tuser, cyc});
  end

  initial begin
    d_out.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      d_out.tready = d_toggle ? !d_out.tready : 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_d(input logic [63:0] data, input logic [7:0] keep, input logic last,
                         input logic user, output int acc_cyc);
    d_in.tdata  = data;
    d_in.tkeep  = keep;
    d_in.tlast  = last;
    d_in.tuser  = user;
    d_in.tvalid = 1'b1;
    acc_cyc     = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (d_in.tready) begin
        acc_cyc = cyc;
        break;
      end
    end
    check_eq("d_accept", 64'(acc_cyc >= 0), 64'd1);
    @(posedge clk);
    #1;
    d_in.tvalid = 1'b0;
  endtask

  task automatic drive_u(input logic [7:0] data, input logic last, input logic user,
                         output int acc_cyc);
    u_in.tdata  = data;
    u_in.tkeep  = 1'b1;
    u_in.tlast  = last;
    u_in.tuser  = user;
    u_in.tvalid = 1'b1;
    acc_cyc     = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_in.tready) begin
        acc_cyc = cyc;
        break;
      end
    end
    check_eq("u_accept", 64'(acc_cyc >= 0), 64'd1);
    @(posedge clk);
    #1;
    u_in.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc;
    logic [63:0] w;
    logic        prev_stall;
    beat_t       prev;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    d_toggle = 1'b0;
    rst      = 1'b0;
    d_in.tvalid  = 1'b0; d_in.tdata = '0; d_in.tkeep = '0; d_in.tlast = 1'b0; d_in.tuser = 1'b0;
    u_in.tvalid  = 1'b0; u_in.tdata = '0; u_in.tkeep = '0; u_in.tlast = 1'b0; u_in.tuser = 1'b0;
    p_in.tvalid  = 1'b0; p_in.tdata = '0; p_in.tkeep = '0; p_in.tlast = 1'b0; p_in.tuser = 1'b0;
    u_out.tready = 1'b1;
    p_out.tready = 1'b1;

    // Reset state.
    #23;
    check_eq("rst_d_valid", 64'(d_out.tvalid), 64'd0);
    check_eq("rst_d_ready", 64'(d_in.tready), 64'd0);
    check_eq("rst_u_valid", 64'(u_out.tvalid), 64'd0);
    check_eq("rst_u_ready", 64'(u_in.tready), 64'd0);
    check_eq("rst_u_data", u_out.tdata, 64'd0);
    check_eq("rst_p_valid", 64'(p_out.tvalid), 64'd0);
    check_eq("rst_p_ready", 64'(p_in.tready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel_d_ready", 64'(d_in.tready), 64'd1);
    check_eq("rel_u_ready", 64'(u_in.tready), 64'd1);
    @(posedge clk);
    #1;

    // 64->8, five valid lanes, final beat.
    d_q.delete();
    drive_d(64'habcdabcdabcdabcd, 8'h1f, 1'b1, 1'b0, acc);
    idle(12);
    check_eq("d1_count", 64'(d_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < d_q.size()) begin
        check_eq($sformatf("d1_data%0d", i), d_q[i].data, (i % 2 == 0) ? 64'hcd : 64'hab);
        check_eq($sformatf("d1_keep%0d", i), 64'(d_q[i].keep), 64'd1);
        check_eq($sformatf("d1_last%0d", i), 64'(d_q[i].last), 64'(i == 4));
        check_eq($sformatf("d1_cyc%0d", i), 64'(d_q[i].cyc - acc), 64'(i + 1));
      end
    end

    // 64->8, two back-to-back beats; the non-final beat's tuser must not appear.
    d_q.delete();
    drive_d(64'h0706050403020100, 8'hff, 1'b0, 1'b1, acc);
    drive_d(64'h0f0e0d0c0b0a0908, 8'hff, 1'b1, 1'b1, acc);
    idle(20);
    check_eq("d2_count", 64'(d_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < d_q.size()) begin
        check_eq($sformatf("d2_data%0d", i), d_q[i].data, 64'(i));
        check_eq($sformatf("d2_last%0d", i), 64'(d_q[i].last), 64'(i == 15));
        check_eq($sformatf("d2_user%0d", i), 64'(d_q[i].user), 64'(i == 15));
        check_eq($sformatf("d2_gap%0d", i), 64'(d_q[i].cyc - d_q[0].cyc), 64'(i));
      end
    end

    // 64->8 with the sink stalling every other cycle.
    d_q.delete();
    d_toggle = 1'b1;
    drive_d(64'h1716151413121110, 8'hff, 1'b1, 1'b0, acc);
    prev_stall = 1'b0;
    prev       = '{64'd0, 8'd0, 1'b0, 1'b0, 0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev_stall) begin
        check_eq("d3_hold_valid", 64'(d_out.tvalid), 64'd1);
        check_eq("d3_hold_data", 64'(d_out.tdata), prev.data);
        check_eq("d3_hold_last", 64'(d_out.tlast), 64'(prev.last));
      end
      if (d_out.tvalid)
        check_eq("d3_in_ready", 64'(d_in.tready), 64'(d_out.tready && d_out.tlast));
      prev_stall = d_out.tvalid && !d_out.tready;
      prev       = '{64'(d_out.tdata), 8'(d_out.tkeep), d_out.tlast, d_out.tuser, cyc};
    end
    d_toggle = 1'b0;
    idle(2);
    check_eq("d3_count", 64'(d_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < d_q.size()) begin
        check_eq($sformatf("d3_data%0d", i), d_q[i].data, 64'(8'h10 + i));
        check_eq($sformatf("d3_last%0d", i), 64'(d_q[i].last), 64'(i == 7));
      end
    end

    // 64->8, empty final beat still produces one beat.
    d_q.delete();
    drive_d(64'h0, 8'h00, 1'b1, 1'b0, acc);
    idle(6);
    check_eq("d4_count", 64'(d_q.size()), 64'd1);
    if (d_q.size() > 0) begin
      check_eq("d4_keep", 64'(d_q[0].keep), 64'd0);
      check_eq("d4_last", 64'(d_q[0].last), 64'd1);
    end

    // 8->64 short frame with tuser on the middle byte.
    u_q.delete();
    drive_u(8'h01, 1'b0, 1'b0, acc);
    drive_u(8'h02, 1'b0, 1'b1, acc);
    drive_u(8'h03, 1'b1, 1'b0, acc);
    idle(4);
    check_eq("u1_count", 64'(u_q.size()), 64'd1);
    if (u_q.size() > 0) begin
      check_eq("u1_data", u_q[0].data, 64'h030201);
      check_eq("u1_keep", 64'(u_q[0].keep), 64'h07);
      check_eq("u1_last", 64'(u_q[0].last), 64'd1);
      check_eq("u1_user", 64'(u_q[0].user), 64'd1);
      check_eq("u1_lat", 64'(u_q[0].cyc - acc), 64'd1);
    end

    // 8->64 full word without tlast.
    u_q.delete();
    for (int i = 0; i < 8; i++) drive_u(8'(8'ha0 + i), 1'b0, 1'b0, acc);
    idle(4);
    check_eq("u2_count", 64'(u_q.size()), 64'd1);
    if (u_q.size() > 0) begin
      check_eq("u2_data", u_q[0].data, 64'ha7a6a5a4a3a2a1a0);
      check_eq("u2_keep", 64'(u_q[0].keep), 64'hff);
      check_eq("u2_last", 64'(u_q[0].last), 64'd0);
      check_eq("u2_user", 64'(u_q[0].user), 64'd0);
      check_eq("u2_lat", 64'(u_q[0].cyc - acc), 64'd1);
    end

    // 32->32 pass-through, one registered stage.
    p_q.delete();
    p_in.tdata  = 32'hdeadbeef;
    p_in.tkeep  = 4'h7;
    p_in.tlast  = 1'b1;
    p_in.tuser  = 1'b1;
    p_in.tvalid = 1'b1;
    @(negedge clk);
    check_eq("p_ready", 64'(p_in.tready), 64'd1);
    w = 64'(cyc);
    @(posedge clk);
    #1;
    p_in.tvalid = 1'b0;
    idle(3);
    check_eq("p_count", 64'(p_q.size()), 64'd1);
    if (p_q.size() > 0) begin
      check_eq("p_data", p_q[0].data, 64'hdeadbeef);
      check_eq("p_keep", 64'(p_q[0].keep), 64'h7);
      check_eq("p_last", 64'(p_q[0].last), 64'd1);
      check_eq("p_user", 64'(p_q[0].user), 64'd1);
      check_eq("p_lat", 64'(p_q[0].cyc) - w, 64'd1);
    end

    // Reset mid-frame after the 2nd of 5 downsize beats.
    d_q.delete();
    drive_d(64'h0000000504030201, 8'h1f, 1'b1, 1'b0, acc);
    for (int i = 0; i < 50 && d_q.size() < 2; i++) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("r_valid", 64'(d_out.tvalid), 64'd0);
    check_eq("r_data", 64'(d_out.tdata), 64'd0);
    check_eq("r_last", 64'(d_out.tlast), 64'd0);
    check_eq("r_ready", 64'(d_in.tready), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("r_rel_ready", 64'(d_in.tready), 64'd1);
    idle(10);
    check_eq("r_count", 64'(d_q.size()), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
